// File: rtl/ising_seq_pkg.sv
// Shared types and constants for the Ising-machine run sequencer.
// Holds the FSM state encoding, core register map and control codes.
package ising_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_START   = 3'd2,
        ST_RUN     = 3'd3,
        ST_STOP    = 3'd4,
        ST_RD_REQ  = 3'd5,
        ST_RD_WAIT = 3'd6,
        ST_FIN     = 3'd7
    } seq_state_t;

    localparam logic [31:0] CTRL_ADDR        = 32'h0000_0000;
    localparam logic [31:0] SPIN_BASE_ADDR   = 32'h0000_0100;

    localparam logic [31:0] CTRL_RESET_SPINS = 32'd0;
    localparam logic [31:0] CTRL_ENABLE_OSC  = 32'd1;
    localparam logic [31:0] CTRL_FREEZE      = 32'd2;

    // Byte address of spin word idx (32-bit words, 4-byte stride).
    function automatic logic [31:0] spin_addr(input logic [3:0] idx);
        return SPIN_BASE_ADDR + {26'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/ising_seq_rdtimer.sv
// Loadable 32-bit down-counter; expire is high while the count is zero.
// One instance times both the anneal duration and the read-data timeout.
module ising_seq_rdtimer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_val,
    input  logic        dec,
    output logic        expired
);

    logic [31:0] count_r;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 32'd0;
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != 32'd0)) begin
            count_r <= count_r - 32'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == 32'd0);

endmodule

// File: rtl/ising_run_seq.sv
// Run sequencer: resets and enables the Ising core, anneals for a set number
// of clocks, freezes it, then reads N_WORDS spin words into a result buffer.
module ising_run_seq
    import ising_seq_pkg::*;
#(
    parameter int unsigned N_WORDS    = 4,
    parameter int unsigned RD_TIMEOUT = 255
) (
    input  logic        clk_main_a0,
    input  logic        rst_main_n,
    input  logic        cmd_start,
    input  logic        cmd_abort,
    input  logic [31:0] cmd_run_cycles,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic [3:0]  res_idx,
    output logic [31:0] res_data,
    output logic        core_wvalid,
    output logic [31:0] core_waddr,
    output logic [31:0] core_wdata,
    output logic        core_arvalid,
    output logic [31:0] core_araddr,
    input  logic        core_rvalid,
    input  logic [31:0] core_rdata,
    input  logic [1:0]  core_rresp,
    output logic        core_rready
);

    localparam logic [3:0]  LAST_IDX     = 4'(N_WORDS - 1);
    localparam logic [4:0]  N_WORDS_W    = 5'(N_WORDS);
    localparam logic [31:0] TIMEOUT_LOAD = 32'(RD_TIMEOUT - 1);

    seq_state_t  state_r;
    logic [3:0]  idx_r;
    logic [31:0] res_buf_r [16];

    logic        timer_load_s;
    logic [31:0] timer_val_s;
    logic        timer_dec_s;
    logic        timer_expired_s;

    ising_seq_rdtimer u_timer (
        .clk      (clk_main_a0),
        .rst_n    (rst_main_n),
        .load     (timer_load_s),
        .load_val (timer_val_s),
        .dec      (timer_dec_s),
        .expired  (timer_expired_s)
    );

    // Timer control: anneal length on start, read timeout on each read request.
    always_comb begin
        timer_load_s = 1'b0;
        timer_val_s  = 32'd0;
        timer_dec_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_start) begin
                    timer_load_s = 1'b1;
                    timer_val_s  = cmd_run_cycles;
                end else begin
                    timer_load_s = 1'b0;
                end
            end
            ST_RUN: begin
                timer_dec_s = 1'b1;
            end
            ST_RD_REQ: begin
                timer_load_s = 1'b1;
                timer_val_s  = TIMEOUT_LOAD;
            end
            ST_RD_WAIT: begin
                timer_dec_s = 1'b1;
            end
            default: begin
                timer_load_s = 1'b0;
            end
        endcase
    end

    // Main sequencer; strobes and flags are registered so they align with the
    // state that owns them (e.g. the HOLD write is visible while in HOLD).
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            state_r      <= ST_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            core_wvalid  <= 1'b0;
            core_waddr   <= 32'd0;
            core_wdata   <= 32'd0;
            core_arvalid <= 1'b0;
            core_araddr  <= 32'd0;
            idx_r        <= 4'd0;
            for (int i = 0; i < 16; i++) begin
                res_buf_r[i] <= 32'd0;
            end
        end else begin
            done         <= 1'b0;
            core_wvalid  <= 1'b0;
            core_arvalid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cmd_start) begin
                        err         <= 1'b0;
                        busy        <= 1'b1;
                        state_r     <= ST_HOLD;
                        core_wvalid <= 1'b1;
                        core_waddr  <= CTRL_ADDR;
                        core_wdata  <= CTRL_RESET_SPINS;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    state_r     <= ST_START;
                    core_wvalid <= 1'b1;
                    core_waddr  <= CTRL_ADDR;
                    core_wdata  <= CTRL_ENABLE_OSC;
                end
                ST_START: begin
                    state_r <= ST_RUN;
                end
                ST_RUN: begin
                    if (cmd_abort) begin
                        state_r     <= ST_FIN;
                        done        <= 1'b1;
                        err         <= 1'b1;
                        core_wvalid <= 1'b1;
                        core_waddr  <= CTRL_ADDR;
                        core_wdata  <= CTRL_RESET_SPINS;
                    end else if (timer_expired_s) begin
                        state_r     <= ST_STOP;
                        idx_r       <= 4'd0;
                        core_wvalid <= 1'b1;
                        core_waddr  <= CTRL_ADDR;
                        core_wdata  <= CTRL_FREEZE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_STOP: begin
                    state_r      <= ST_RD_REQ;
                    core_arvalid <= 1'b1;
                    core_araddr  <= spin_addr(idx_r);
                end
                ST_RD_REQ: begin
                    if (cmd_abort) begin
                        state_r     <= ST_FIN;
                        done        <= 1'b1;
                        err         <= 1'b1;
                        core_wvalid <= 1'b1;
                        core_waddr  <= CTRL_ADDR;
                        core_wdata  <= CTRL_RESET_SPINS;
                    end else begin
                        state_r <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    // Abort outranks a coincident read beat, whose data is dropped.
                    if (cmd_abort) begin
                        state_r     <= ST_FIN;
                        done        <= 1'b1;
                        err         <= 1'b1;
                        core_wvalid <= 1'b1;
                        core_waddr  <= CTRL_ADDR;
                        core_wdata  <= CTRL_RESET_SPINS;
                    end else if (core_rvalid) begin
                        res_buf_r[idx_r] <= core_rdata;
                        if (core_rresp != 2'b00) begin
                            err <= 1'b1;
                        end else begin
                            err <= err;
                        end
                        if (idx_r == LAST_IDX) begin
                            state_r <= ST_FIN;
                            done    <= 1'b1;
                        end else begin
                            idx_r        <= idx_r + 4'd1;
                            state_r      <= ST_RD_REQ;
                            core_arvalid <= 1'b1;
                            core_araddr  <= spin_addr(idx_r + 4'd1);
                        end
                    end else if (timer_expired_s) begin
                        state_r <= ST_FIN;
                        done    <= 1'b1;
                        err     <= 1'b1;
                    end else begin
                        state_r <= ST_RD_WAIT;
                    end
                end
                ST_FIN: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign core_rready = (state_r == ST_RD_WAIT);

    // Out-of-range indices read as zero.
    always_comb begin
        if ({1'b0, res_idx} < N_WORDS_W) begin
            res_data = res_buf_r[res_idx];
        end else begin
            res_data = 32'd0;
        end
    end

endmodule

// File: tb/tb_ising_run_seq.sv
// Bench for ising_run_seq: table-driven and random runs against a run-level
// model of writes, reads, buffer contents, error and done behaviour.
module tb_ising_run_seq;

    localparam int NW = 4;
    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        rst_main_n = 1'b1;
    logic        cmd_start = 1'b0;
    logic        cmd_abort = 1'b0;
    logic [31:0] cmd_run_cycles = 32'd0;
    logic        busy, done, err;
    logic [3:0]  res_idx = 4'd0;
    logic [31:0] res_data;
    logic        core_wvalid, core_arvalid, core_rready;
    logic [31:0] core_waddr, core_wdata, core_araddr;
    logic        core_rvalid = 1'b0;
    logic [31:0] core_rdata = 32'd0;
    logic [1:0]  core_rresp = 2'b00;

    ising_run_seq #(.N_WORDS(NW), .RD_TIMEOUT(TO)) dut (
        .clk_main_a0    (clk),
        .rst_main_n     (rst_main_n),
        .cmd_start      (cmd_start),
        .cmd_abort      (cmd_abort),
        .cmd_run_cycles (cmd_run_cycles),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .res_idx        (res_idx),
        .res_data       (res_data),
        .core_wvalid    (core_wvalid),
        .core_waddr     (core_waddr),
        .core_wdata     (core_wdata),
        .core_arvalid   (core_arvalid),
        .core_araddr    (core_araddr),
        .core_rvalid    (core_rvalid),
        .core_rdata     (core_rdata),
        .core_rresp     (core_rresp),
        .core_rready    (core_rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cycles;
        int          abort_k;     // observation index at which abort is raised, -1 none
        int          abort_word;  // abort together with this word's read beat, -1 none
        int          drop_word;   // core never answers this word, -1 none
        int          bad_word;    // this word answers with rresp=2'b10, -1 none
        int          max_delay;
        bit          chk_tbl;
        logic        exp_err;
        int          exp_nwr;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_buf [16];
    logic [31:0] w_data  [16];
    logic [1:0]  w_resp  [16];
    int          w_delay [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_buffer(input string tag);
        for (int i = 0; i < 16; i++) begin
            res_idx = 4'(i);
            #1;
            check($sformatf("%s_buf%0d", tag, i), res_data, (i < NW) ? exp_buf[i] : 32'd0);
        end
        @(posedge clk); #1;
    endtask

    task automatic run_case(input vec_t v, input string tag);
        int unsigned wq[$];
        logic [31:0] aq[$];
        int unsigned ew[$];
        int start_k = -1, stop_k = -1, done_k = -1, last_ar_k = -1;
        int done_cnt = 0, excl_bad = 0, addr_bad = 0;
        int w = 0, cnt = 0;
        bit pend = 1'b0, finished = 1'b0, abort_in_run;
        int stopper, nreads;
        logic m_err;

        for (int i = 0; i < 16; i++) begin
            w_data[i]  = $urandom;
            w_resp[i]  = (i == v.bad_word) ? 2'b10 : 2'b00;
            w_delay[i] = $urandom_range(0, v.max_delay);
        end
        cmd_start      = 1'b1;
        cmd_run_cycles = v.cycles;
        for (int k = 1; k <= 3000 && !finished; k++) begin
            @(posedge clk); #1;
            cmd_start   = 1'b0;
            cmd_abort   = 1'b0;
            core_rvalid = 1'b0;
            if (core_wvalid && core_arvalid) excl_bad++;
            if (core_wvalid) begin
                wq.push_back(core_wdata);
                if (core_waddr != 32'd0) addr_bad++;
                if (core_wdata == 32'd1) start_k = k;
                if (core_wdata == 32'd2) stop_k = k;
            end
            if (core_arvalid) begin
                aq.push_back(core_araddr);
                pend = 1'b1;
                cnt = w_delay[w];
                last_ar_k = k;
            end
            if (done) begin
                done_cnt++;
                done_k = k;
            end
            if (pend && core_rready && (w != v.drop_word)) begin
                if (cnt == 0) begin
                    core_rvalid = 1'b1;
                    core_rdata  = w_data[w];
                    core_rresp  = w_resp[w];
                    if (w == v.abort_word) cmd_abort = 1'b1;
                    pend = 1'b0;
                    w++;
                end else begin
                    cnt--;
                end
            end
            if (k == v.abort_k) cmd_abort = 1'b1;
            if (k == 2) begin
                cmd_start      = 1'b1;   // extra request while busy
                cmd_run_cycles = 32'd3;
            end
            if (done_k > 0 && k == done_k + 4) finished = 1'b1;
        end
        cmd_start = 1'b0; cmd_abort = 1'b0; core_rvalid = 1'b0;
        check({tag, "_timeout"}, 32'(finished), 32'd1);

        // Run-level model derived from the sequencing rules.
        abort_in_run = (v.abort_k >= 3) && (v.abort_k <= int'(v.cycles) + 3);
        stopper = (v.abort_word >= 0) ? v.abort_word : v.drop_word;
        nreads  = abort_in_run ? 0 : ((stopper >= 0) ? stopper + 1 : NW);
        ew.push_back(0); ew.push_back(1);
        if (abort_in_run) ew.push_back(0);
        else begin
            ew.push_back(2);
            if (v.abort_word >= 0) ew.push_back(0);
        end
        m_err = abort_in_run || (stopper >= 0) ||
                (v.bad_word >= 0 && v.bad_word < nreads && v.bad_word != stopper);
        for (int i = 0; i < nreads; i++)
            if (i != stopper) exp_buf[i] = w_data[i];

        check({tag, "_err"}, 32'(err), 32'(m_err));
        if (v.chk_tbl) begin
            check({tag, "_err_tbl"}, 32'(err), 32'(v.exp_err));
            check({tag, "_nwr_tbl"}, wq.size(), v.exp_nwr);
        end
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_excl"}, excl_bad, 0);
        check({tag, "_waddr"}, addr_bad, 0);
        check({tag, "_nwr"}, wq.size(), ew.size());
        for (int i = 0; i < wq.size() && i < ew.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), wq[i], ew[i]);
        check({tag, "_nrd"}, aq.size(), nreads);
        for (int i = 0; i < aq.size() && i < nreads; i++)
            check($sformatf("%s_ra%0d", tag, i), aq[i], 32'h100 + 32'(4 * i));
        if (abort_in_run) check({tag, "_abort_lat"}, done_k, v.abort_k + 1);
        else check({tag, "_run_cycles"}, stop_k - start_k - 1, int'(v.cycles) + 1);
        if (v.drop_word >= 0) check({tag, "_to_lat"}, done_k - last_ar_k, TO + 1);
        check_buffer(tag);
    endtask

    initial begin
        vec_t tbl[7];
        vec_t rv;
        bit   seen;

        //          cyc abk abw drw bad dly tbl err nwr
        tbl[0] = '{10, -1, -1, -1, -1, 0, 1'b1, 1'b0, 3};
        tbl[1] = '{5,  -1, -1, -1,  1, 2, 1'b1, 1'b1, 3};
        tbl[2] = '{0,  -1, -1, -1, -1, 3, 1'b1, 1'b0, 3};
        tbl[3] = '{3,  -1, -1,  2, -1, 1, 1'b1, 1'b1, 3};
        tbl[4] = '{10,  6, -1, -1, -1, 0, 1'b1, 1'b1, 3};
        tbl[5] = '{4,  -1,  2, -1, -1, 3, 1'b1, 1'b1, 4};
        tbl[6] = '{0,   3, -1, -1, -1, 0, 1'b1, 1'b1, 3};
        for (int i = 0; i < 16; i++) exp_buf[i] = 32'd0;

        #1 rst_main_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_wvalid", 32'(core_wvalid), 32'd0);
        check("rst_arvalid", 32'(core_arvalid), 32'd0);
        check("rst_rready", 32'(core_rready), 32'd0);
        check("rst_res0", res_data, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_main_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_case(tbl[i], $sformatf("tbl%0d", i));

        for (int r = 0; r < 6; r++) begin
            rv = '{$urandom_range(0, 20), -1, -1, -1, -1, $urandom_range(0, 5), 1'b0, 1'b0, 0};
            rv.bad_word = $urandom_range(0, 4);
            if (rv.bad_word == 4) rv.bad_word = -1;
            run_case(rv, $sformatf("rnd%0d", r));
        end

        // Reset while the sequencer waits for read data.
        cmd_start = 1'b1; cmd_run_cycles = 32'd2;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(posedge clk); #1;
            cmd_start = 1'b0;
            if (core_rready) seen = 1'b1;
        end
        check("rstmid_reach_wait", 32'(seen), 32'd1);
        @(posedge clk); #2;
        rst_main_n = 1'b0;
        #1;
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_done", 32'(done), 32'd0);
        check("rstmid_wvalid", 32'(core_wvalid), 32'd0);
        check("rstmid_arvalid", 32'(core_arvalid), 32'd0);
        check("rstmid_rready", 32'(core_rready), 32'd0);
        for (int i = 0; i < 16; i++) exp_buf[i] = 32'd0;
        @(posedge clk); #1;
        rst_main_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        check("rstmid_no_done", 32'(seen), 32'd0);
        check_buffer("rstmid");
        run_case(tbl[0], "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
